prog_frame_loader: RTL and testbench
====================================

Name: prog_frame_loader

Overview:
- Host-side master for the 16-entry instruction-memory write port of the tiny RISC core: write-enable, 4-bit address, 8-bit data, one write per cycle.
- Accepts a byte stream over valid/ready and parses framed program images.
- Stages each frame's payload and commits it to instruction memory only after the checksum matches.
- Holds the core in reset while a frame is being received or committed.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- CSUM_INIT, 8'h00, initial value of the checksum accumulator.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  loader accepts byte this cycle
- wr_en  out  1  instruction-memory write strobe
- wr_addr  out  4  write address
- wr_data  out  8  write data
- cpu_hold  out  1  high = keep core in reset/stalled
- done  out  1  one-cycle pulse after last commit write
- err  out  1  sticky checksum-error flag; cleared at next SYNC
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0) returns to IDLE mid-frame or mid-commit and discards the staged buffer. Output reset values: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0, busy=0.
- Byte transfer occurs on a cycle where in_valid & in_ready. in_ready is combinational from state: 1 in IDLE/HDR/DATA/CSUM, 0 in COMMIT.
- Frame format, in order:
  - SYNC.
  - HDR = {start[7:4], cnt_m1[3:0]}; payload length N = cnt_m1+1, range 1..16.
  - N data bytes.
  - CSUM.
- Checksum: CSUM must equal (CSUM_INIT + HDR + sum of data bytes) mod 256.
- FSM states: IDLE, HDR, DATA, CSUM, COMMIT.
  - IDLE: bytes other than SYNC_BYTE are dropped. On SYNC: err<=0, cpu_hold<=1, go to HDR.
  - HDR: latch start and N; acc <= CSUM_INIT+HDR; idx<=0; go to DATA.
  - DATA: buf[idx]<=byte; acc+=byte; idx++. When idx reaches N-1 on a transfer, go to CSUM. A SYNC-valued byte here is payload, not a restart.
  - CSUM, match: go to COMMIT with idx<=0.
  - CSUM, mismatch: err<=1, cpu_hold<=0, back to IDLE; instruction memory is untouched.
  - COMMIT: one write per cycle with wr_en=1, wr_addr=(start+idx) mod 16, wr_data=buf[idx]. After the N-th write: wr_en<=0, done pulses 1 cycle, cpu_hold<=0, go to IDLE.
- Latency: the first wr_en is asserted 1 cycle after the CSUM transfer. A commit takes exactly N cycles. cpu_hold falls in the cycle done is high.
- Address wrap: start=14, N=4 writes addresses 14,15,0,1.
- wr_en/wr_addr/wr_data are registered, and wr_addr/wr_data hold their last values when wr_en=0.
- No timeout: a stalled host leaves the loader in HDR/DATA/CSUM with cpu_hold=1 indefinitely. Recovery is rst_n only.
- err persists through subsequent IDLE until the next SYNC is accepted.
- The staging buffer is a 16x8 register array. Entries beyond N are don't-care and never written out.

Decomposition:
- Shared package loader_pkg: state enum, SYNC default, header field positions (START_MSB=7, START_LSB=4, CNT_MSB=3, CNT_LSB=0), MEM_DEPTH=16.
- One natural sub-module, loader_stage_buf: 16x8 staging RAM with a write port (DATA state) and a read port (COMMIT state).
- The FSM and checksum accumulator stay in the top block.

Test Plan:
- Frame A5, 03, 11, 22, 33, 44, CSUM=(03+11+22+33+44)=AD → four writes at addresses 0..3 with data 11,22,33,44 on consecutive cycles; done pulses once; cpu_hold falls with done; err=0.
- Bad checksum: same frame with CSUM=AE → no wr_en ever; err=1; cpu_hold returns to 0; a following good frame clears err on its SYNC.
- Wrap and full length: HDR=EF (start 14, N=16), data 00..0F → wr_addr sequence 14,15,0,…,13 with data 00..0F; exactly 16 wr_en cycles.
- Garbage and backpressure:
  - Leading bytes 00, FF, 5A are dropped, then a valid frame loads normally.
  - in_valid toggles randomly → frame still loads correctly.
  - in_ready=0 for all N cycles of COMMIT.
- SYNC-valued payload plus mid-commit reset:
  - Payload byte A5 is written as data.
  - rst_n pulsed low during the 2nd COMMIT cycle → wr_en drops immediately; cpu_hold=0, busy=0; a subsequent frame loads cleanly.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory frame loader.
// No logic of its own; imported by the loader top and its staging buffer.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_COMMIT
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    localparam int START_MSB = 7;
    localparam int START_LSB = 4;
    localparam int CNT_MSB   = 3;
    localparam int CNT_LSB   = 0;

    localparam int MEM_DEPTH = 16;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    // Instruction memory is exactly MEM_DEPTH deep, so commit addresses wrap naturally.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/loader_stage_buf.sv
// 16x8 staging RAM: synchronous write while receiving payload, combinational read while committing.
// Reset clears the contents so an aborted frame leaves nothing behind.
module loader_stage_buf
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_frame_loader.sv
// Parses SYNC/HDR/DATA/CSUM frames from a byte stream and commits verified payloads to instruction memory.
// First write one cycle after the checksum byte, N back-to-back writes; in_ready drops only while committing.
module prog_frame_loader
    import loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter logic [7:0] CSUM_INIT = 8'h00
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic              busy
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] start_q, start_nxt;
    logic [ADDR_W-1:0] cnt_q, cnt_nxt;
    logic [ADDR_W-1:0] idx_q, idx_nxt;
    logic [7:0]        acc_q, acc_nxt;
    logic              err_nxt;
    logic              hold_nxt;
    logic              wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [7:0]        wr_data_nxt;
    logic              done_nxt;

    logic              xfer;
    logic              buf_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    assign in_ready = (state != S_COMMIT);
    assign busy     = (state != S_IDLE);
    assign xfer     = in_valid & in_ready;

    loader_stage_buf u_stage_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_we),
        .wr_addr (idx_q),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            start_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            acc_q    <= 8'h00;
            err      <= 1'b0;
            cpu_hold <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            start_q  <= start_nxt;
            cnt_q    <= cnt_nxt;
            idx_q    <= idx_nxt;
            acc_q    <= acc_nxt;
            err      <= err_nxt;
            cpu_hold <= hold_nxt;
            wr_en    <= wr_en_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_nxt   = start_q;
        cnt_nxt     = cnt_q;
        idx_nxt     = idx_q;
        acc_nxt     = acc_q;
        err_nxt     = err;
        hold_nxt    = cpu_hold;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        done_nxt    = 1'b0;
        buf_we      = 1'b0;
        // While committing, prefetch the entry for the write after the one on the bus.
        rd_addr     = idx_q + 4'd1;

        case (state)
            S_IDLE: begin
                if (xfer && in_data == SYNC_BYTE) begin
                    err_nxt   = 1'b0;
                    hold_nxt  = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    start_nxt = in_data[START_MSB:START_LSB];
                    cnt_nxt   = in_data[CNT_MSB:CNT_LSB];
                    acc_nxt   = CSUM_INIT + in_data;
                    idx_nxt   = '0;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    buf_we  = 1'b1;
                    acc_nxt = acc_q + in_data;
                    idx_nxt = idx_q + 4'd1;
                    if (idx_q == cnt_q) begin
                        state_nxt = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                rd_addr = '0;
                if (xfer) begin
                    if (in_data == acc_q) begin
                        // Launch the first write now so it lands one cycle after the checksum.
                        idx_nxt     = '0;
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = start_q;
                        wr_data_nxt = rd_data;
                        state_nxt   = S_COMMIT;
                    end else begin
                        err_nxt   = 1'b1;
                        hold_nxt  = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_COMMIT: begin
                if (idx_q == cnt_q) begin
                    done_nxt  = 1'b1;
                    hold_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt     = idx_q + 4'd1;
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = wrap_addr(start_q, idx_q + 4'd1);
                    wr_data_nxt = rd_data;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_frame_loader.sv
// Randomized frame streams checked against a frame-level parsing model of the loader.
module tb_prog_frame_loader;

    typedef logic [7:0] byte_t;
    localparam byte_t SYNC  = 8'hA5;
    localparam byte_t CINIT = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    byte_t      in_data = 8'h00;
    logic       in_ready, wr_en, cpu_hold, done, err, busy;
    logic [3:0] wr_addr;
    byte_t      wr_data;

    always #5 clk = ~clk;

    prog_frame_loader #(.SYNC_BYTE(SYNC), .CSUM_INIT(CINIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_xfer_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int exp_done = 0;
    int exp_err = 0;

    byte_t      stream[$];
    byte_t      pl[$];
    logic [3:0] exp_a[$];
    byte_t      exp_d[$];
    logic [3:0] obs_a[$];
    byte_t      obs_d[$];
    int         obs_c[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            obs_a.push_back(wr_addr);
            obs_d.push_back(wr_data);
            obs_c.push_back(cyc);
            chk("rdy_in_commit", int'(in_ready), 0);
            chk("hold_in_commit", int'(cpu_hold), 1);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("hold_with_done", int'(cpu_hold), 0);
        end
    end

    // Frame-level reference: find SYNC, read the header, sum the frame, emit writes if it verifies.
    task automatic model_stream();
        int i = 0;
        exp_a.delete();
        exp_d.delete();
        exp_done = 0;
        while (i < stream.size()) begin
            int hdr, n, st, sum;
            if (stream[i] != SYNC) begin
                i++;
                continue;
            end
            hdr = int'(stream[i+1]);
            n   = hdr % 16 + 1;
            st  = hdr / 16;
            sum = int'(CINIT) + hdr;
            for (int k = 0; k < n; k++) sum += int'(stream[i+2+k]);
            if (sum % 256 == int'(stream[i+2+n])) begin
                for (int k = 0; k < n; k++) begin
                    exp_a.push_back(4'((st + k) % 16));
                    exp_d.push_back(stream[i+2+k]);
                end
                exp_done++;
                exp_err = 0;
            end else begin
                exp_err = 1;
            end
            i += n + 3;
        end
    endtask

    task automatic push_frame(input byte_t hdr, input bit bad);
        byte_t s;
        s = CINIT + hdr;
        stream.push_back(SYNC);
        stream.push_back(hdr);
        foreach (pl[k]) begin
            stream.push_back(pl[k]);
            s = s + pl[k];
        end
        stream.push_back(bad ? s + 8'h01 : s);
    endtask

    // Called at a negedge; returns at the negedge right after the byte is accepted.
    task automatic send_byte(input byte_t b, input int max_gap);
        int gap;
        int waited = 0;
        gap = $urandom_range(0, max_gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk("ready_timeout", int'(in_ready), 1);
        @(negedge clk);
        last_xfer_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic begin_stream();
        model_stream();
        obs_a.delete();
        obs_d.delete();
        obs_c.delete();
        done_cnt = 0;
    endtask

    task automatic end_stream();
        int t = 0;
        int m;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("wr_count", obs_a.size(), exp_a.size());
        m = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
        for (int k = 0; k < m; k++) begin
            chk("wr_addr", int'(obs_a[k]), int'(exp_a[k]));
            chk("wr_data", int'(obs_d[k]), int'(exp_d[k]));
            chk("wr_consec", obs_c[k], obs_c[0] + k);
        end
        if (obs_c.size() > 0) begin
            chk("first_wr_lat", obs_c[0], last_xfer_cyc);
            chk("done_after_last", done_cyc, obs_c[obs_c.size()-1] + 1);
        end
        chk("done_cnt", done_cnt, exp_done);
        chk("err", int'(err), exp_err);
        chk("hold_idle", int'(cpu_hold), 0);
        chk("busy_idle", int'(busy), 0);
        chk("ready_idle", int'(in_ready), 1);
    endtask

    task automatic run_stream(input int max_gap);
        begin_stream();
        foreach (stream[i]) send_byte(stream[i], max_gap);
        end_stream();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_cpu_hold", int'(cpu_hold), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic four-byte frame at address 0.
        stream.delete();
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_frame(8'h03, 1'b0);
        run_stream(0);

        // Same frame with a corrupted checksum; err must persist in IDLE.
        stream.delete();
        push_frame(8'h03, 1'b1);
        run_stream(0);
        repeat (5) @(negedge clk);
        chk("err_sticky", int'(err), 1);

        // Next SYNC clears err immediately.
        stream.delete();
        pl = '{8'h7E};
        push_frame(8'h00, 1'b0);
        begin_stream();
        send_byte(stream[0], 0);
        chk("err_clr_sync", int'(err), 0);
        chk("hold_on_sync", int'(cpu_hold), 1);
        chk("busy_on_sync", int'(busy), 1);
        for (int i = 1; i < stream.size(); i++) send_byte(stream[i], 0);
        end_stream();

        // Full length frame wrapping from address 14.
        stream.delete();
        pl.delete();
        for (int k = 0; k < 16; k++) pl.push_back(8'(k));
        push_frame(8'hEF, 1'b0);
        run_stream(0);

        // Leading garbage, then a frame with random input gaps.
        stream = '{8'h00, 8'hFF, 8'h5A};
        pl = '{8'($urandom), 8'($urandom), 8'($urandom)};
        push_frame(8'h52, 1'b0);
        run_stream(3);

        // SYNC-valued payload bytes.
        stream.delete();
        pl = '{SYNC, 8'h01, SYNC};
        push_frame(8'h72, 1'b0);
        run_stream(2);

        for (int r = 0; r < 10; r++) begin
            byte_t hdr;
            byte_t g;
            int n;
            stream.delete();
            pl.delete();
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h00;
                stream.push_back(g);
            end
            hdr = 8'($urandom);
            n = int'(hdr[3:0]) + 1;
            for (int k = 0; k < n; k++)
                pl.push_back(($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom));
            push_frame(hdr, $urandom_range(0, 3) == 0);
            run_stream(3);
        end

        // Reset in the second commit cycle aborts the load.
        stream.delete();
        pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        push_frame(8'h23, 1'b0);
        foreach (stream[i]) send_byte(stream[i], 0);
        chk("commit_lat", int'(wr_en), 1);
        @(negedge clk);
        chk("commit_2nd_addr", int'(wr_addr), 3);
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", int'(wr_en), 0);
        chk("arst_hold", int'(cpu_hold), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 0;
        @(negedge clk);

        stream.delete();
        pl = '{8'h5D, 8'hE0};
        push_frame(8'h91, 1'b0);
        run_stream(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
